// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner for the EXE stage. It runs MULT/MULTU/DIV/DIVU as a
// 32-step radix-2 shift-add multiply or restoring divide, and handles the
// MTHI/MTLO/MFHI/MFLO moves. It stalls EXE while an op is in flight.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no op in flight; moves complete here, MULT/DIV start here
// ITER  | one multiply/divide step per edge, count 0..XLEN-1
// FIX   | sign correction and HI/LO write, then back to IDLE
module hilo_muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter bit DEBUG = 1'b0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FLUSH,
    input  logic            Op_Valid,
    input  logic [3:0]      Op_Code,
    input  logic [XLEN-1:0] OperandA,
    input  logic [XLEN-1:0] OperandB,
    output logic            Stall,
    output logic            Busy,
    output logic [XLEN-1:0] Result,
    output logic            Done,
    output logic [XLEN-1:0] HI_OUT,
    output logic [XLEN-1:0] LO_OUT
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LP_LAST = CW'(XLEN - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    // r_acc_hi: running partial product high half / running remainder
    // r_acc_lo: multiplier shifting out / dividend shifting out, quotient in
    logic [XLEN-1:0]   r_acc_hi;
    logic [XLEN-1:0]   r_acc_lo;
    logic [XLEN-1:0]   r_opnd;
    logic [CW-1:0]     r_count;
    logic              r_is_div;
    logic              r_sign_q;
    logic              r_sign_r;
    logic              r_divz;
    logic              r_done;

    logic              w_op_legal;
    logic              w_accept;
    logic              w_start_md;
    logic              w_is_div;
    logic              w_is_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN-1:0]   w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic              w_fix_write;

    // Trace hook: printing stays out of the synthesizable datapath; a
    // simulation monitor can be bound here when DEBUG is set.
    if (DEBUG) begin : g_trace
    end

    assign w_op_legal  = (Op_Code >= OP_MULT) && (Op_Code <= OP_MFLO);
    assign w_accept    = (r_state == S_IDLE) && Op_Valid && !FLUSH && w_op_legal;
    assign w_start_md  = w_accept && (Op_Code <= OP_DIVU);
    assign w_is_div    = (Op_Code == OP_DIV) || (Op_Code == OP_DIVU);
    assign w_is_signed = (Op_Code == OP_MULT) || (Op_Code == OP_DIV);
    assign w_a_neg     = w_is_signed && OperandA[XLEN-1];
    assign w_b_neg     = w_is_signed && OperandB[XLEN-1];
    assign w_a_abs     = w_a_neg ? -OperandA : OperandA;
    assign w_b_abs     = w_b_neg ? -OperandB : OperandB;

    // One shift-add step: add multiplicand when the current multiplier bit
    // is set, then shift the 2*XLEN+1 accumulator right by one.
    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});

    // One restoring-divide step. The remainder stays below the divisor, so
    // the shifted value fits XLEN+1 bits and the difference fits XLEN bits.
    assign w_div_shift = {r_acc_hi, r_acc_lo[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[XLEN-1:0] - r_opnd;

    assign w_prod      = {r_acc_hi, r_acc_lo};
    assign w_prod_fix  = r_sign_q ? -w_prod : w_prod;
    // Divide by zero leaves the all-ones quotient unsigned-looking; the
    // remainder fix still restores the original dividend.
    assign w_quo_fix   = (r_sign_q && !r_divz) ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix   = r_sign_r ? -r_acc_hi : r_acc_hi;
    assign w_fix_write = (r_state == S_FIX) && !FLUSH;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; FLUSH aborts any in-flight op.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_start_md) w_state_nxt = S_ITER;
            S_ITER: begin
                if (FLUSH) begin
                    w_state_nxt = S_IDLE;
                end else if (r_count == LP_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch at start and one iteration step per edge in ITER.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opnd   <= '0;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_divz   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_start_md) begin
                r_acc_hi <= '0;
                r_acc_lo <= w_is_div ? w_a_abs : w_b_abs;
                r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
                r_count  <= '0;
                r_is_div <= w_is_div;
                r_sign_q <= w_a_neg ^ w_b_neg;
                r_sign_r <= w_a_neg;
                r_divz   <= w_is_div && (OperandB == '0);
            end
        end else if (r_state == S_ITER) begin
            r_count <= r_count + CW'(1);
            if (r_is_div) begin
                r_acc_hi <= w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0];
                r_acc_lo <= {r_acc_lo[XLEN-2:0], w_div_ge};
            end else begin
                r_acc_hi <= w_mul_sum[XLEN:1];
                r_acc_lo <= {w_mul_sum[0], r_acc_lo[XLEN-1:1]};
            end
        end
    end

    // Architectural HI/LO: moves in IDLE, MULT/DIV results only from FIX.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept && (Op_Code == OP_MTHI)) begin
            r_hi <= OperandA;
        end else if (w_accept && (Op_Code == OP_MTLO)) begin
            r_lo <= OperandA;
        end else if (w_fix_write) begin
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else begin
                r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                r_lo <= w_prod_fix[XLEN-1:0];
            end
        end
    end

    // Completion pulse for the cycle after the FIX write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix_write;
        end
    end

    // Read port for MFHI/MFLO.
    always_comb begin
        Result = '0;
        if (Op_Valid && (Op_Code == OP_MFHI)) begin
            Result = r_hi;
        end else if (Op_Valid && (Op_Code == OP_MFLO)) begin
            Result = r_lo;
        end
    end

    assign Stall  = Op_Valid && w_op_legal && (r_state != S_IDLE) && !FLUSH;
    assign Busy   = (r_state != S_IDLE);
    assign Done   = r_done;
    assign HI_OUT = r_hi;
    assign LO_OUT = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: expected HI/LO pairs are queued
// when a MULT/DIV is issued and compared when Done is seen.
module tb_hilo_muldiv_sequencer;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            FLUSH;
    logic            Op_Valid;
    logic [3:0]      Op_Code;
    logic [XLEN-1:0] OperandA;
    logic [XLEN-1:0] OperandB;
    logic            Stall;
    logic            Busy;
    logic [XLEN-1:0] Result;
    logic            Done;
    logic [XLEN-1:0] HI_OUT;
    logic [XLEN-1:0] LO_OUT;

    hilo_muldiv_sequencer #(.XLEN(XLEN), .DEBUG(1'b0)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .FLUSH    (FLUSH),
        .Op_Valid (Op_Valid),
        .Op_Code  (Op_Code),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .Stall    (Stall),
        .Busy     (Busy),
        .Result   (Result),
        .Done     (Done),
        .HI_OUT   (HI_OUT),
        .LO_OUT   (LO_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        sb.push_back(e);
    endtask

    // Present one request for one cycle; returns at the negedge after the
    // accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Op_Valid = 1'b1;
        Op_Code  = op;
        OperandA = a;
        OperandB = b;
        @(negedge CLK);
        Op_Valid = 1'b0;
        Op_Code  = OP_NOP;
    endtask

    task automatic wait_done(output int busy_n, output bit got);
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (Done) begin
                got = 1'b1;
                break;
            end
            if (Busy) busy_n++;
            @(negedge CLK);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, HI_OUT, e.hi);
            chk({tag, "_lo"}, LO_OUT, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end else begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end
    endtask

    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        int busy_n;
        bit got;
        push_exp(hi, lo);
        issue(op, a, b);
        chk({tag, "_hold_hi"}, HI_OUT, m_hi);
        chk({tag, "_hold_lo"}, LO_OUT, m_lo);
        wait_done(busy_n, got);
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        chk({tag, "_busy_cycles"}, busy_n, XLEN + 1);
        pop_compare(tag);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_n;
        int done_n;
        RESET    = 1'b1;
        FLUSH    = 1'b0;
        Op_Valid = 1'b0;
        Op_Code  = OP_NOP;
        OperandA = '0;
        OperandB = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        chk("rst_hi",     HI_OUT, 32'h0);
        chk("rst_lo",     LO_OUT, 32'h0);
        chk("rst_busy",   {31'd0, Busy}, 32'd0);
        chk("rst_done",   {31'd0, Done}, 32'd0);
        chk("rst_stall",  {31'd0, Stall}, 32'd0);
        chk("rst_result", Result, 32'h0);

        run_md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
        run_md("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_md("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_z",    OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        run_md("div_z",     OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_md("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_md("divu_100",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

        // MFLO held behind a MULTU: stalled through ITER and FIX.
        push_exp(32'h0, 32'h2A);
        @(negedge CLK);
        Op_Valid = 1'b1;
        Op_Code  = OP_MULTU;
        OperandA = 32'd6;
        OperandB = 32'd7;
        @(negedge CLK);
        Op_Code = OP_MFLO;
        #1;
        stall_n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!Stall) break;
            stall_n++;
            @(negedge CLK);
            #1;
        end
        chk("mflo_stall_cycles", stall_n, XLEN + 1);
        chk("mflo_stall_low", {31'd0, Stall}, 32'd0);
        chk("mflo_result", Result, 32'h0000_002A);
        chk("mflo_done", {31'd0, Done}, 32'd1);
        pop_compare("mflo");
        @(negedge CLK);
        Op_Valid = 1'b0;
        Op_Code  = OP_NOP;

        // MTHI, then a flushed MTHI in IDLE must not write.
        issue(OP_MTHI, 32'h1111_1111, 32'h0);
        m_hi = 32'h1111_1111;
        chk("mthi_hi", HI_OUT, m_hi);
        @(negedge CLK);
        FLUSH    = 1'b1;
        Op_Valid = 1'b1;
        Op_Code  = OP_MTHI;
        OperandA = 32'hDEAD_BEEF;
        @(negedge CLK);
        FLUSH    = 1'b0;
        Op_Valid = 1'b0;
        Op_Code  = OP_NOP;
        chk("flush_idle_hi", HI_OUT, m_hi);

        // DIVU flushed at count 10; NOP never stalls, FLUSH masks stall.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge CLK);
        Op_Valid = 1'b1;
        Op_Code  = OP_NOP;
        #1;
        chk("nop_no_stall", {31'd0, Stall}, 32'd0);
        @(negedge CLK);
        FLUSH   = 1'b1;
        Op_Code = OP_MFHI;
        #1;
        chk("flush_no_stall", {31'd0, Stall}, 32'd0);
        chk("flush_busy_before", {31'd0, Busy}, 32'd1);
        @(negedge CLK);
        FLUSH    = 1'b0;
        Op_Valid = 1'b0;
        Op_Code  = OP_NOP;
        chk("flush_busy_after", {31'd0, Busy}, 32'd0);
        done_n = 0;
        repeat (40) begin
            if (Done) done_n++;
            @(negedge CLK);
        end
        chk("flush_no_done", done_n, 0);
        chk("flush_iter_hi", HI_OUT, m_hi);
        chk("flush_iter_lo", LO_OUT, m_lo);

        // FLUSH in FIX beats the HI/LO write.
        issue(OP_MULTU, 32'd3, 32'd3);
        repeat (XLEN) @(negedge CLK);
        chk("fix_busy", {31'd0, Busy}, 32'd1);
        FLUSH = 1'b1;
        @(negedge CLK);
        FLUSH = 1'b0;
        chk("fix_flush_busy", {31'd0, Busy}, 32'd0);
        chk("fix_flush_done", {31'd0, Done}, 32'd0);
        chk("fix_flush_hi", HI_OUT, m_hi);
        chk("fix_flush_lo", LO_OUT, m_lo);

        // RESET during ITER, then MTLO/MFLO.
        issue(OP_MULT, 32'd5, 32'd5);
        repeat (5) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("iter_rst_hi", HI_OUT, m_hi);
        chk("iter_rst_lo", LO_OUT, m_lo);
        chk("iter_rst_busy", {31'd0, Busy}, 32'd0);
        issue(OP_MTLO, 32'h0000_1234, 32'h0);
        Op_Valid = 1'b1;
        Op_Code  = OP_MFLO;
        #1;
        chk("mtlo_mflo_result", Result, 32'h0000_1234);
        chk("mtlo_mflo_stall", {31'd0, Stall}, 32'd0);
        @(negedge CLK);
        Op_Valid = 1'b0;
        Op_Code  = OP_NOP;
        chk("post_rst_no_done", {31'd0, Done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
